// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//
// Multi-channel input conditioner for asynchronous, bouncy board-level
// signals (push-buttons, external reset pins, strap switches). Each channel
// runs through a SYNC_STAGES-deep synchroniser followed by a debounce counter
// that only accepts a new level once it has persisted for DEBOUNCE_CYCLES
// consecutive synchronised cycles.
//
// Parameters:
//   N               number of independent channels (>= 1)
//   SYNC_STAGES     synchroniser flops per channel (>= 2)
//   DEBOUNCE_CYCLES cycles a new value must persist before acceptance (>= 1)
//   RESET_VALUE     value loaded into the synchroniser and dout on reset
//
// Ports:
//   clk    in   1  system clock
//   rst_n  in   1  synchronous active-low reset
//   din    in   N  asynchronous raw inputs
//   dout   out  N  debounced, synchronised levels
//   rise   out  N  one-cycle strobe on an accepted 0->1 transition of dout
//   fall   out  N  one-cycle strobe on an accepted 1->0 transition of dout
//
// Build option:
//   DEBOUNCE_SYNC_EDGE_EN  when defined, the rise/fall strobe registers are
//                          built; otherwise rise and fall are tied to zero.
// -----------------------------------------------------------------------------
module debounce_sync #(
  parameter int             N               = 1,
  parameter int             SYNC_STAGES     = 3,
  parameter int             DEBOUNCE_CYCLES = 250000,
  parameter logic [N-1:0]   RESET_VALUE     = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]  sync_q [SYNC_STAGES];
  logic [N-1:0]  s;
  logic [N-1:0]  dout_q, dout_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  assign s    = sync_q[SYNC_STAGES-1];
  assign dout = dout_q;

  // Synchroniser chain, debounced level and per-channel counters. The chain
  // is a plain shift register so each stage has a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RESET_VALUE;
      end
      dout_q <= RESET_VALUE;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      dout_q <= dout_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Debounce decision. A channel whose synchronised value matches dout drops
  // any accumulated progress. A mismatching channel counts up, and on the
  // cycle the count has already reached DEBOUNCE_CYCLES-1 the new value is
  // accepted. The count stops at DEBOUNCE_CYCLES-1, so it can never wrap.
  always_comb begin
    dout_d = dout_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s[i] != dout_q[i]) begin
        if (cnt_q[i] == LAST) begin
          dout_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

`ifdef DEBOUNCE_SYNC_EDGE_EN
  logic [N-1:0] rise_q, fall_q;

  // Strobes are registered alongside dout, so they are high exactly in the
  // cycle where dout first shows the newly accepted value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= dout_d & ~dout_q;
      fall_q <= ~dout_d & dout_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce_sync
//
// Bench for debounce_sync with N=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// RESET_VALUE=2'b01. A window-based reference model predicts dout/rise/fall
// on every edge; directed scenarios add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_debounce_sync;

  localparam int         N    = 2;
  localparam int         S    = 2;
  localparam int         D    = 4;
  localparam logic [1:0] RV   = 2'b01;
  localparam int         MAXE = 4096;

`ifdef DEBOUNCE_SYNC_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] din;
  logic [1:0] dout;
  logic [1:0] rise;
  logic [1:0] fall;

  int passCount;
  int checkCount;

  debounce_sync #(
    .N              (N),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .RESET_VALUE    (RV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall)
  );

  // Free-running clock, first rising edge at 5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single place where every comparison is counted and reported.
  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
    checkCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end else begin
      passCount++;
    end
  endtask

  // Inputs are changed at a falling edge, far from the sampling edge.
  task automatic applyStimulus(input logic r, input logic [1:0] d);
    rst_n = r;
    din   = d;
  endtask

  // Reference model. It records what was applied at each rising edge and
  // derives outputs from the rules directly: the synchronised value is the
  // input from SYNC_STAGES-1 edges back (or RESET_VALUE if reset happened in
  // that window), and a channel flips only when the synchronised value seen
  // at each of the last DEBOUNCE_CYCLES edges was the opposite of dout with
  // no reset in between.
  int         e;
  bit         seenReset;
  bit         rstH  [MAXE];
  logic [1:0] dinH  [MAXE];
  logic [1:0] sH    [MAXE];
  logic [1:0] doutM, riseM, fallM;

  initial begin
    e         = 0;
    seenReset = 1'b0;
  end

  always @(posedge clk) begin
    logic [1:0] prev;
    bit         anyR;
    bit         ok;
    e++;
    if (e >= MAXE) begin
      $display("[TB] FAIL model_capacity: edge %0d, limit %0d", e, MAXE);
      $fatal(1);
    end
    rstH[e] = !rst_n;
    dinH[e] = din;
    anyR = 1'b0;
    for (int k = e - S + 1; k <= e; k++) begin
      if (k < 1 || rstH[k]) anyR = 1'b1;
    end
    sH[e] = anyR ? RV : dinH[e - S + 1];
    if (rstH[e]) begin
      seenReset = 1'b1;
      doutM = RV;
      riseM = 2'b00;
      fallM = 2'b00;
    end else begin
      prev = doutM;
      for (int c = 0; c < N; c++) begin
        ok = 1'b1;
        for (int k = e - D + 1; k <= e; k++) begin
          if (k < 1 || rstH[k]) ok = 1'b0;
        end
        for (int k = e - D; k <= e - 1; k++) begin
          if (k < 1) ok = 1'b0;
          else if (sH[k][c] === prev[c]) ok = 1'b0;
        end
        if (ok) doutM[c] = ~prev[c];
      end
      riseM = doutM & ~prev;
      fallM = ~doutM & prev;
    end
  end

  // Per-cycle comparison against the model once the first reset has landed.
  always @(negedge clk) begin
    if (seenReset) begin
      checkOutput("model_dout", dout, doutM);
      checkOutput("model_rise", rise, EDGE_EN ? riseM : 2'b00);
      checkOutput("model_fall", fall, EDGE_EN ? fallM : 2'b00);
      checkOutput("rise_fall_overlap", rise & fall, 2'b00);
    end
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    passCount  = 0;
    checkCount = 0;
    applyStimulus(1'b0, 2'b10);

    // Reset held for 3 edges, then 5 quiet edges after release.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_dout", dout, 2'b01);
      checkOutput("reset_rise", rise, 2'b00);
      checkOutput("reset_fall", fall, 2'b00);
    end
    applyStimulus(1'b1, 2'b01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post_reset_dout", dout, 2'b01);
      checkOutput("post_reset_rise", rise, 2'b00);
      checkOutput("post_reset_fall", fall, 2'b00);
    end

    // Channel 1 rises at edge 6 after the change.
    applyStimulus(1'b1, 2'b11);
    repeat (5) @(negedge clk);
    checkOutput("rise1_edge5_dout", dout, 2'b01);
    checkOutput("rise1_edge5_rise", rise, 2'b00);
    @(negedge clk);
    checkOutput("rise1_edge6_dout", dout, 2'b11);
    checkOutput("rise1_edge6_rise", rise, EDGE_EN ? 2'b10 : 2'b00);
    checkOutput("rise1_edge6_fall", fall, 2'b00);
    @(negedge clk);
    checkOutput("rise1_edge7_rise", rise, 2'b00);

    // Channel 0 glitches low for 3 cycles: one short of acceptance.
    applyStimulus(1'b1, 2'b10);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 2'b11);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("glitch0_dout", dout, 2'b11);
      checkOutput("glitch0_fall", fall, 2'b00);
    end

    // Channel 1 toggles every 2 cycles, then settles low.
    for (int p = 0; p < 10; p++) begin
      applyStimulus(1'b1, (p % 2 == 0) ? 2'b01 : 2'b11);
      repeat (2) begin
        @(negedge clk);
        checkOutput("toggle1_dout", dout, 2'b11);
      end
    end
    applyStimulus(1'b1, 2'b01);
    repeat (5) @(negedge clk);
    checkOutput("settle1_edge5_dout", dout, 2'b11);
    @(negedge clk);
    checkOutput("settle1_edge6_dout", dout, 2'b01);
    checkOutput("settle1_edge6_fall", fall, EDGE_EN ? 2'b10 : 2'b00);
    checkOutput("settle1_edge6_rise", rise, 2'b00);
    @(negedge clk);
    checkOutput("settle1_edge7_fall", fall, 2'b00);

    // Both channels flip on the same edge.
    applyStimulus(1'b1, 2'b10);
    repeat (5) @(negedge clk);
    checkOutput("both_edge5_dout", dout, 2'b01);
    @(negedge clk);
    checkOutput("both_edge6_dout", dout, 2'b10);
    checkOutput("both_edge6_rise", rise, EDGE_EN ? 2'b10 : 2'b00);
    checkOutput("both_edge6_fall", fall, EDGE_EN ? 2'b01 : 2'b00);
    @(negedge clk);
    checkOutput("both_edge7_rise", rise, 2'b00);
    checkOutput("both_edge7_fall", fall, 2'b00);

    // Return to 2'b01, then reset in the middle of a pending rise.
    applyStimulus(1'b1, 2'b01);
    repeat (10) @(negedge clk);
    checkOutput("restore_dout", dout, 2'b01);
    applyStimulus(1'b1, 2'b11);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 2'b11);
    @(negedge clk);
    checkOutput("midreset_dout", dout, 2'b01);
    checkOutput("midreset_rise", rise, 2'b00);
    applyStimulus(1'b1, 2'b11);
    repeat (5) begin
      @(negedge clk);
      checkOutput("after_rel_dout", dout, 2'b01);
      checkOutput("after_rel_rise", rise, 2'b00);
    end
    @(negedge clk);
    checkOutput("after_rel_edge6_dout", dout, 2'b11);
    checkOutput("after_rel_edge6_rise", rise, EDGE_EN ? 2'b10 : 2'b00);
    @(negedge clk);
    checkOutput("after_rel_edge7_rise", rise, 2'b00);

    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Parametrised multi-channel input conditioner for asynchronous, bouncy signals such as push-buttons, external reset pins and strap/mode switches. Each channel passes through a configurable-depth synchroniser and a per-channel debounce counter. It produces a clean level plus optional single-cycle edge strobes, all in the `clk` domain. It sits at the board-pin boundary, ahead of the reset distribution and user-control logic.

## Interface
Parameters:
- `N`, 1: number of independent channels (≥1).
- `SYNC_STAGES`, 3: synchroniser flops per channel (≥2).
- `DEBOUNCE_CYCLES`, 250000: consecutive synchronised cycles a new value must persist before acceptance (≥1).
- `RESET_VALUE`, all ones: `[N-1:0]` value loaded into the synchroniser and `dout` on reset.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous active-low reset, sampled on `posedge clk`.
- `din`  in  N  asynchronous raw inputs.
- `dout`  out  N  debounced, synchronised levels.
- `rise`  out  N  one-cycle strobe on an accepted 0→1 transition of `dout`.
- `fall`  out  N  one-cycle strobe on an accepted 1→0 transition of `dout`.

## Operation
- Channels are fully independent; no shared state.
- Synchroniser: `SYNC_STAGES`-deep shift chain. `s[i]` is the last stage. No logic sits between stages.
- Counter per channel, width `$clog2(DEBOUNCE_CYCLES+1)`, unsigned, never wraps.
- Each edge, per channel, with `rst_n` high:
  - `s[i] == dout[i]`: counter ← 0, `dout` holds, strobes 0.
  - `s[i] != dout[i]` and counter `== DEBOUNCE_CYCLES-1`: `dout[i]` ← `s[i]`, counter ← 0, and `rise[i]`/`fall[i]` ← 1 according to the new value.
  - `s[i] != dout[i]` otherwise: counter ← counter+1, `dout` holds.
- Any cycle where `s` matches `dout` discards accumulated progress. A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never reaches `dout`.
- Reset (`rst_n` low at an edge): all synchroniser stages ← `RESET_VALUE`, `dout` ← `RESET_VALUE`, counters ← 0, `rise`/`fall` ← 0. Reset mid-count abandons the pending transition. The count restarts after release only if the input still differs.
- Simultaneous transitions on several channels each complete independently, in the same cycle when their timing is identical.

## Timing
- All outputs are registered; there is no combinational path from `din` or `rst_n`.
- `din` change settling before edge 1: `s` reflects it after edge `SYNC_STAGES`. `dout` changes at edge `SYNC_STAGES + DEBOUNCE_CYCLES`.
- `rise`/`fall` are high for exactly the cycle in which `dout` first shows the new value. They are low in all other cycles.
- `rise[i]` and `fall[i]` are never high together.
- Reset values: `dout = RESET_VALUE`, `rise = 0`, `fall = 0`. The first legal strobe occurs at least `SYNC_STAGES+DEBOUNCE_CYCLES` edges after `rst_n` rises.
- `DEBOUNCE_CYCLES = 1`: `dout` follows `s` with one cycle of delay and no filtering.

## Configuration
- Macro `DEBOUNCE_SYNC_EDGE_EN`.
- Defined: the `rise`/`fall` strobe registers are built as specified above.
- Undefined: no strobe registers are built. `rise` and `fall` are tied to 0, and the ports remain present. `dout` behaviour is identical in both builds.

## Test plan
Parameters for all scenarios: `N=2`, `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4`, `RESET_VALUE=2'b01`; macro defined unless stated.

1. Hold `rst_n=0` for 3 edges with `din=2'b10` → `dout=2'b01`, `rise=fall=0` throughout reset and for the following 5 edges.
2. After reset, `din[1]` 0→1 held → `dout[1]=1` exactly at edge 6 after the change, `rise[1]=1` for that single cycle only, channel 0 untouched.
3. `din[0]` low for 3 cycles, then back high → `dout[0]` stays 1, `fall[0]` never asserts.
4. `din[1]` toggling every 2 cycles for 20 cycles, then held 0 from a known `dout[1]=1` → exactly one `fall[1]` strobe, 6 edges after the final toggle.
5. `din` 2'b01→2'b10 on the same edge → `dout=2'b10` on one edge, with `rise[1]` and `fall[0]` asserted together for one cycle. Repeat with the macro undefined → same `dout`, strobes stay 0.
6. `din[1]` 0→1, assert `rst_n=0` at edge 4 for 1 cycle, keep `din[1]=1` → `dout[1]` held at 0 through reset, then rises 6 edges after `rst_n` release with one `rise[1]` strobe.
